// File: rtl/sha3_pkg.sv
// Shared constants and FSM state type for the SHA3 absorb-side block packer.
package sha3_pkg;

  localparam int unsigned LANE_W     = 64;
  localparam int unsigned RATE_LANES = 17;
  localparam int unsigned RATE_W     = LANE_W * RATE_LANES;  // 1088 for SHA3-256
  localparam int unsigned MSG_LEN_W  = 16;
  localparam logic [7:0]  PAD_DOMAIN = 8'h06;
  localparam int unsigned PAD_END    = 63;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_PAD  = 3'd2,
    ST_HOLD = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/sha3_absorb_packer.sv
// Packs FIFO lanes into SHA3 rate blocks, applies the 0x06..80 pad on the
// final block and hands each block to the permutation core over valid/ready.
module sha3_absorb_packer #(
  parameter int unsigned LANE_W     = sha3_pkg::LANE_W,
  parameter int unsigned RATE_LANES = sha3_pkg::RATE_LANES
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [sha3_pkg::MSG_LEN_W-1:0] msg_lanes,
  output logic                           fifo_read,
  input  logic [LANE_W-1:0]              fifo_data,
  input  logic                           fifo_empty,
  output logic [LANE_W*RATE_LANES-1:0]   block_data,
  output logic                           block_valid,
  input  logic                           block_ready,
  output logic                           block_last,
  output logic                           busy,
  output logic                           done
);
  import sha3_pkg::*;

  localparam int unsigned      IDX_W    = $clog2(RATE_LANES + 1);
  localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(RATE_LANES);
  localparam int unsigned      TOP_LANE = RATE_LANES - 1;

  state_t                 state;
  state_t                 state_next;
  logic [IDX_W-1:0]       lane_idx;
  logic [IDX_W-1:0]       lane_idx_next;
  logic [MSG_LEN_W-1:0]   remaining;
  logic [MSG_LEN_W-1:0]   remaining_next;
  logic                   last_next;
  logic                   pop;
  logic                   clr_block;
  logic                   do_pad;
  logic [LANE_W-1:0]      lanes [RATE_LANES];

  // Pop is combinational so the FWFT head word is written on the same edge.
  assign fifo_read = pop;

  // Flatten the lane array onto the block bus, lane i at [LANE_W*i +: LANE_W].
  for (genvar g = 0; g < RATE_LANES; g++) begin : g_flat
    assign block_data[g*LANE_W +: LANE_W] = lanes[g];
  end

  // Next-state, counter and datapath-control decode.
  always_comb begin
    state_next     = state;
    lane_idx_next  = lane_idx;
    remaining_next = remaining;
    last_next      = 1'b0;
    pop            = 1'b0;
    clr_block      = 1'b0;
    do_pad         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next     = ST_FILL;
          clr_block      = 1'b1;
          lane_idx_next  = '0;
          remaining_next = msg_lanes;
        end
      end
      ST_FILL: begin
        if (remaining == '0) begin
          // Only reachable on entry with an empty message.
          state_next = ST_PAD;
        end else if (!fifo_empty) begin
          pop            = 1'b1;
          lane_idx_next  = lane_idx + IDX_W'(1);
          remaining_next = remaining - MSG_LEN_W'(1);
          if (lane_idx_next == IDX_FULL) begin
            state_next = ST_HOLD;
          end else if (remaining_next == '0) begin
            state_next = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        do_pad     = 1'b1;
        last_next  = 1'b1;
        state_next = ST_HOLD;
      end
      ST_HOLD: begin
        last_next = block_last;
        if (block_ready) begin
          if (block_last) begin
            state_next = ST_DONE;
          end else begin
            // Next block starts from a clean lane array in either case.
            clr_block     = 1'b1;
            lane_idx_next = '0;
            state_next    = (remaining != '0) ? ST_FILL : ST_PAD;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      lane_idx    <= '0;
      remaining   <= '0;
      block_valid <= 1'b0;
      block_last  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      lane_idx    <= lane_idx_next;
      remaining   <= remaining_next;
      block_valid <= (state_next == ST_HOLD);
      block_last  <= (state_next == ST_HOLD) && last_next;
      busy        <= (state_next != ST_IDLE);
      done        <= (state_next == ST_DONE);
    end
  end

  // Lane array: clear per block, write popped lanes, then overlay padding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RATE_LANES; i++) lanes[i] <= '0;
    end else if (clr_block) begin
      for (int i = 0; i < RATE_LANES; i++) lanes[i] <= '0;
    end else begin
      if (pop) begin
        lanes[lane_idx] <= fifo_data;
      end
      if (do_pad) begin
        lanes[lane_idx]           <= lanes[lane_idx] ^ LANE_W'(PAD_DOMAIN);
        // Later assignment merges the end bit even when lane_idx is the top lane.
        lanes[TOP_LANE][PAD_END] <= 1'b1;
      end
    end
  end

endmodule
